mc_ctrl: RTL

Multi-cycle control FSM for the MIPS-subset core. It sequences the PC register, instruction register, register file, ALU and data memory across FETCH/DECODE/EXEC/MEM/WB. It drives the next-PC unit's 2-bit op select: 00 PC+4, 01 beq target gated by eq, 10 jump, 11 register. It also counts retired instructions.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_ctrl_if.sv | 41 ++++
 rtl/mc_decode.sv | 37 +++
 rtl/mc_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS-subset control unit.
// Holds the FSM state codes, opcode/funct constants, the datapath select
// encodings driven by mc_ctrl, and the one-hot instruction class vector
// produced by mc_decode.
package mc_pkg;

    // State codes are visible on the debug port, so their values are fixed.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    // Next-PC unit select
    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    // Register file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register file write-data select
    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_MEM = 2'b01;
    localparam logic [1:0] WDSEL_PC4 = 2'b10;

    // Exactly one field is set for any op/funct combination.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic nop;
    } insn_class_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: groups the control unit's datapath-facing signals.
//   master (control unit): inputs op, funct, imem_ready, dmem_ready;
//                          outputs state, enables, selects, retire, insn_cnt
//   slave  (datapath/observer): the mirror image
interface mc_ctrl_if
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [5:0]       op;
    logic [5:0]       funct;
    logic             imem_ready;
    logic             dmem_ready;
    state_t           state;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       npc_op;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic [1:0]       alu_op;
    logic             alu_src_b;
    logic             ext_op;
    logic             mem_we;
    logic             retire;
    logic [CNT_W-1:0] insn_cnt;

    modport master (
        input  op, funct, imem_ready, dmem_ready,
        output state, ir_we, pc_we, npc_op, reg_we, reg_dst, wd_sel,
               alu_op, alu_src_b, ext_op, mem_we, retire, insn_cnt
    );

    modport slave (
        output op, funct, imem_ready, dmem_ready,
        input  state, ir_we, pc_we, npc_op, reg_we, reg_dst, wd_sel,
               alu_op, alu_src_b, ext_op, mem_we, retire, insn_cnt
    );

endinterface

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction classifier.
//   op    in  6  IR[31:26]
//   funct in  6  IR[5:0]
//   cls   out    one-hot class vector; anything unrecognised is nop
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output insn_class_t cls
);

    // funct only matters for R-type; every unmatched encoding falls to nop
    // so the FSM always has exactly one class to act on.
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: cls.addu = 1'b1;
                    FUNCT_SUBU: cls.subu = 1'b1;
                    FUNCT_JR:   cls.jr   = 1'b1;
                    default:    cls.nop  = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset core.
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   bus    master modport of mc_ctrl_if: op/funct/ready inputs, FSM state,
//          datapath enables and selects, retire pulse, retired-insn counter
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB, skipping phases an
// instruction does not need, and counts retired instructions.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus
);

    state_t           state_q;
    state_t           state_d;
    insn_class_t      cls;
    logic [CNT_W-1:0] cnt_q;

    logic             ir_we_c;
    logic             pc_we_c;
    logic             reg_we_c;
    logic             mem_we_c;
    logic [1:0]       npc_op;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic [1:0]       alu_op;
    logic             alu_src_b;
    logic             ext_op;

    mc_decode u_decode (
        .op    (bus.op),
        .funct (bus.funct),
        .cls   (cls)
    );

    // State register; reset abandons whatever instruction was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.retire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next-state and output decode. Every instruction retires through
    // exactly one pc_we cycle: DECODE for jumps/NOP, EXEC for beq, the
    // dmem_ready cycle of MEM for sw, and WB for everything else.
    always_comb begin
        state_d   = state_q;
        ir_we_c   = 1'b0;
        pc_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        npc_op    = NPC_PC4;
        reg_dst   = REGDST_RT;
        wd_sel    = WDSEL_ALU;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        ext_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we_c = bus.imem_ready;
                if (bus.imem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (cls.j || cls.jal) begin
                    pc_we_c = 1'b1;
                    npc_op  = NPC_J;
                    state_d = S_FETCH;
                    if (cls.jal) begin
                        reg_we_c = 1'b1;
                        reg_dst  = REGDST_RA;
                        wd_sel   = WDSEL_PC4;
                    end
                end else if (cls.jr) begin
                    pc_we_c = 1'b1;
                    npc_op  = NPC_JR;
                    state_d = S_FETCH;
                end else if (cls.nop) begin
                    pc_we_c = 1'b1;
                    npc_op  = NPC_PC4;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (cls.beq) begin
                    // The next-PC unit picks target vs PC+4 from eq itself.
                    alu_op    = ALU_SUB;
                    alu_src_b = 1'b0;
                    pc_we_c   = 1'b1;
                    npc_op    = NPC_BR;
                    state_d   = S_FETCH;
                end else if (cls.lw || cls.sw) begin
                    alu_op    = ALU_ADD;
                    alu_src_b = 1'b1;
                    ext_op    = 1'b1;
                    state_d   = S_MEM;
                end else begin
                    state_d   = S_WB;
                end
            end

            S_MEM: begin
                // Address stays on the ALU output for the whole access.
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
                if (cls.sw) begin
                    mem_we_c = 1'b1;
                    if (bus.dmem_ready) begin
                        pc_we_c = 1'b1;
                        npc_op  = NPC_PC4;
                        state_d = S_FETCH;
                    end
                end else if (bus.dmem_ready) begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                pc_we_c  = 1'b1;
                npc_op   = NPC_PC4;
                reg_we_c = 1'b1;
                state_d  = S_FETCH;
                if (cls.addu || cls.subu) begin
                    reg_dst = REGDST_RD;
                    wd_sel  = WDSEL_ALU;
                    alu_op  = cls.subu ? ALU_SUB : ALU_ADD;
                end else if (cls.ori) begin
                    reg_dst   = REGDST_RT;
                    wd_sel    = WDSEL_ALU;
                    alu_op    = ALU_OR;
                    alu_src_b = 1'b1;
                    ext_op    = 1'b0;
                end else if (cls.lui) begin
                    reg_dst   = REGDST_RT;
                    wd_sel    = WDSEL_ALU;
                    alu_op    = ALU_LUI;
                    alu_src_b = 1'b1;
                end else if (cls.lw) begin
                    reg_dst = REGDST_RT;
                    wd_sel  = WDSEL_MEM;
                end
            end

            // Codes 5-7 recover to FETCH without touching anything.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables are suppressed during reset so an abandoned instruction
    // leaves no architectural side effects.
    assign bus.ir_we     = ir_we_c  & ~reset;
    assign bus.pc_we     = pc_we_c  & ~reset;
    assign bus.reg_we    = reg_we_c & ~reset;
    assign bus.mem_we    = mem_we_c & ~reset;
    assign bus.retire    = pc_we_c  & ~reset;
    assign bus.state     = state_q;
    assign bus.npc_op    = npc_op;
    assign bus.reg_dst   = reg_dst;
    assign bus.wd_sel    = wd_sel;
    assign bus.alu_op    = alu_op;
    assign bus.alu_src_b = alu_src_b;
    assign bus.ext_op    = ext_op;
    assign bus.insn_cnt  = cnt_q;

endmodule
